ysyx_23060187_muldiv: RTL



---
 rtl/ysyx_23060187_muldiv_pkg.sv | 23 ++
 rtl/ysyx_23060187_muldiv_step.sv | 36 +++
 rtl/ysyx_23060187_muldiv.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ysyx_23060187_muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: fun3 op codes,
// sequencer states and the default datapath width.
package ysyx_23060187_muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ysyx_23060187_muldiv_step.sv
// One radix-2 iteration shared by multiply (shift-add) and divide
// (restoring trial-subtract) on the 2*XLEN accumulator.
module ysyx_23060187_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next,
  output logic              q_bit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    acc_next = '0;
    q_bit    = 1'b0;
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    if (!is_div) begin
      // Upper half accumulates, lower half holds the unconsumed multiplier bits.
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {sum, acc[XLEN-1:1]};
    end else begin
      // Partial remainder stays below the divisor, so bit XLEN of diff is a pure borrow.
      rem_sh   = acc[2*XLEN-1:XLEN-1];
      diff     = rem_sh - {1'b0, operand};
      q_bit    = ~diff[XLEN];
      acc_next = {(q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ysyx_23060187_muldiv.sv
// RV32M multiply/divide sequencer: magnitude capture, XLEN iterative steps,
// sign fix-up and valid/ready handshakes on both sides.
module ysyx_23060187_muldiv
  import ysyx_23060187_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t              state_reg, state_next;
  logic [2:0]          op_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic [XLEN-1:0]     operand_reg;
  logic                neg_reg;
  logic [XLEN-1:0]     result_reg;

  logic                accept;
  logic                div_zero;
  logic                signed_a, signed_b, sa, sb, neg_in;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [2*XLEN-1:0]   acc_step;
  logic                q_bit;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot, rem, fix_val;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = result_reg;

  assign accept   = in_valid & in_ready & ~flush;
  assign div_zero = op[2] & (src2 == '0);

  always_comb begin
    signed_a = (op == MULH) | (op == MULHSU) | (op == DIV) | (op == REM);
    signed_b = (op == MULH) | (op == DIV) | (op == REM);
    sa       = signed_a & src1[XLEN-1];
    sb       = signed_b & src2[XLEN-1];
    a_mag    = sa ? -src1 : src1;
    b_mag    = sb ? -src2 : src2;
    // Remainder takes the dividend's sign; product and quotient take the xor.
    neg_in   = (op == REM) ? sa : (sa ^ sb);
  end

  ysyx_23060187_muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc_reg),
    .operand  (operand_reg),
    .is_div   (op_reg[2]),
    .acc_next (acc_step),
    .q_bit    (q_bit)
  );

  always_comb begin
    prod_fix = neg_reg ? -acc_reg : acc_reg;
    quot     = acc_reg[XLEN-1:0];
    rem      = acc_reg[2*XLEN-1:XLEN];
    fix_val  = '0;
    case (op_reg)
      MUL:                  fix_val = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:            fix_val = neg_reg ? -quot : quot;
      default:              fix_val = neg_reg ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) state_next = div_zero ? DONE : CALC;
        CALC: if (cnt_reg == LAST) state_next = FIX;
        FIX:  state_next = DONE;
        DONE: if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= '0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      operand_reg <= '0;
      neg_reg     <= 1'b0;
      result_reg  <= '0;
    end else if (!flush) begin
      case (state_reg)
        IDLE: if (accept) begin
          op_reg      <= op;
          cnt_reg     <= '0;
          acc_reg     <= {{XLEN{1'b0}}, a_mag};
          operand_reg <= b_mag;
          neg_reg     <= neg_in;
          if (div_zero) result_reg <= op[1] ? src1 : '1;
        end
        CALC: begin
          acc_reg <= acc_step | {{(2*XLEN-1){1'b0}}, q_bit};
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX: result_reg <= fix_val;
        default: ;
      endcase
    end
  end

endmodule
